hazard_controller: RTL and testbench
====================================

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: maximum consecutive MEM_WAIT cycles before bus error.
REQ-002 Parameter CNT_W, default 16: width of the performance counters.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST_N  input  1  reset, asynchronous, active-low.
REQ-005 ARS1_IF_ID, ARS2_IF_ID  input  5 each  source register addresses of the instruction in decode.
REQ-006 ARD_ID_EX  input  5  destination register of the instruction in EX.
REQ-007 MEMREAD_ID_EX  input  1  the instruction in EX is a load.
REQ-008 BRANCH_TAKEN_EX  input  1  branch/jump resolved taken in EX.
REQ-009 DMEM_REQ_EX_MEM  input  1  the instruction in MEM accesses data memory.
REQ-010 DMEM_READY  input  1  data memory completes the access this cycle.
REQ-011 PC_WRITE, IF_ID_WRITE, ID_EX_WRITE, EX_MEM_WRITE, MEM_WB_WRITE  output  1 each  pipeline register enables.
REQ-012 IF_ID_FLUSH, ID_EX_FLUSH  output  1 each  replace register contents with a bubble.
REQ-013 BUS_ERROR  output  1  sticky memory timeout flag.
REQ-014 STALL_COUNT, FLUSH_COUNT  output  CNT_W each  saturating performance counters.

Function
REQ-015 FSM states SHALL be RUN, MEM_WAIT, ERROR.
REQ-016 RUN -> MEM_WAIT when DMEM_REQ_EX_MEM=1 and DMEM_READY=0; MEM_WAIT -> RUN on DMEM_READY=1; MEM_WAIT -> ERROR when the wait counter reaches MEM_TIMEOUT-1 with DMEM_READY=0; ERROR is left only via reset.
REQ-017 Wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle.
REQ-018 Memory stall (state RUN with DMEM_REQ_EX_MEM=1, DMEM_READY=0, or state MEM_WAIT with DMEM_READY=0, or state ERROR): all five *_WRITE=0, both flushes 0.
REQ-019 A MEM_WAIT cycle with DMEM_READY=1 SHALL be a normal cycle (no memory stall) in which REQ-020/021 apply.
REQ-020 Branch flush (no memory stall, BRANCH_TAKEN_EX=1): IF_ID_FLUSH=1, ID_EX_FLUSH=1, all *_WRITE=1, same cycle.
REQ-021 Load-use (no memory stall, no branch, MEMREAD_ID_EX=1, ARD_ID_EX!=0, ARD_ID_EX equals ARS1_IF_ID or ARS2_IF_ID): PC_WRITE=0, IF_ID_WRITE=0, ID_EX_FLUSH=1, other writes 1; exactly one bubble per load.
REQ-022 Otherwise all *_WRITE=1 and flushes 0.
REQ-023 Priority SHALL be memory stall > branch flush > load-use; a branch held in EX during a memory stall flushes on the first released cycle.
REQ-024 Register x0 (address 0) SHALL never cause a load-use stall.
REQ-025 BUS_ERROR SHALL set on the MEM_WAIT->ERROR transition and remain 1 until reset.
REQ-026 STALL_COUNT SHALL increment each cycle PC_WRITE=0 with RST_N high; FLUSH_COUNT each cycle IF_ID_FLUSH=1; both saturate at all-ones, no wrap.
REQ-027 Enables and flushes are combinational from state and inputs (zero latency); state, wait counter, BUS_ERROR and counters are registered.

Reset
REQ-028 RST_N low SHALL immediately force state RUN, wait counter 0, BUS_ERROR 0, both counters 0, all *_WRITE 0, both flushes 0, including mid-MEM_WAIT or in ERROR.
REQ-029 First rising edge after RST_N deasserts SHALL operate as state RUN.

Structure
REQ-030 A shared package hazard_pkg SHALL hold the state enum and default MEM_TIMEOUT and CNT_W values.
REQ-031 One sub-module sat_counter (parameterised width, increment enable, async active-low reset) SHALL be instantiated twice.

Verification
REQ-032 Load x5 in EX, ARS2_IF_ID=5 -> one cycle PC_WRITE=0, IF_ID_WRITE=0, ID_EX_FLUSH=1; STALL_COUNT=1.
REQ-033 Load with ARD_ID_EX=0, ARS1_IF_ID=0 -> no stall, all writes 1.
REQ-034 DMEM_READY low 3 cycles with BRANCH_TAKEN_EX=1 held -> 3 cycles all writes 0, then one flush cycle; STALL_COUNT=3, FLUSH_COUNT=1.
REQ-035 DMEM_READY held low 16 cycles -> ERROR, BUS_ERROR=1 and stays 1; RST_N pulse clears it and all counters.
REQ-036 Load-use and taken branch in the same cycle -> flush only, PC_WRITE=1, no stall counted.
REQ-037 Force STALL_COUNT to 0xFFFF via long stalls -> stays 0xFFFF.

Source files
------------

// File: rtl/hazard_controller_pkg.sv
// Shared types and default sizing for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  localparam int DEF_MEM_TIMEOUT = 16;
  localparam int DEF_CNT_W       = 16;

  // Wait counter must hold MEM_TIMEOUT-1; never narrower than one bit.
  function automatic int wait_width(input int timeout);
    return (timeout > 2) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline-side hazard signals: decode/EX/MEM status in, register enables,
// flushes and status out.
interface hazard_controller_if
  import hazard_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);

  logic [4:0]       ars1_if_id;
  logic [4:0]       ars2_if_id;
  logic [4:0]       ard_id_ex;
  logic             memread_id_ex;
  logic             branch_taken_ex;
  logic             dmem_req_ex_mem;
  logic             dmem_ready;

  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_write;
  logic             ex_mem_write;
  logic             mem_wb_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             bus_error;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output ars1_if_id, ars2_if_id, ard_id_ex, memread_id_ex,
           branch_taken_ex, dmem_req_ex_mem, dmem_ready,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
           if_id_flush, id_ex_flush, bus_error, stall_count, flush_count
  );

  modport slave (
    input  ars1_if_id, ars2_if_id, ard_id_ex, memread_id_ex,
           branch_taken_ex, dmem_req_ex_mem, dmem_ready,
    output pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
           if_id_flush, id_ex_flush, bus_error, stall_count, flush_count
  );

endinterface

// File: rtl/hazard_controller_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: memory-wait stalls with timeout, taken-branch
// flushes, load-use bubbles, and saturating stall/flush performance counters.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input logic                clk,
  input logic                rst_n,
  hazard_controller_if.slave hz
);

  localparam int WAIT_W = wait_width(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state_q;
  state_t            state_d;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic              bus_error_q;

  logic mem_stall;
  logic load_use;
  logic pc_we;
  logic if_id_we;
  logic id_ex_we;
  logic ex_mem_we;
  logic mem_wb_we;
  logic if_id_fl;
  logic id_ex_fl;

  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  assign load_use = hz.memread_id_ex && (hz.ard_id_ex != 5'd0) &&
                    ((hz.ard_id_ex == hz.ars1_if_id) ||
                     (hz.ard_id_ex == hz.ars2_if_id));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Counter only advances while waiting, so it is already zero on entry.
      if (state_q == ST_MEM_WAIT) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end else begin
        wait_cnt_q <= '0;
      end
      if ((state_q == ST_MEM_WAIT) && (state_d == ST_ERROR)) begin
        bus_error_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_stall = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (hz.dmem_req_ex_mem && !hz.dmem_ready) begin
          state_d   = ST_MEM_WAIT;
          mem_stall = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (hz.dmem_ready) begin
          state_d = ST_RUN;
        end else begin
          mem_stall = 1'b1;
          if (wait_cnt_q == WAIT_LAST) begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_ERROR: begin
        mem_stall = 1'b1;
      end
      default: begin
        state_d   = ST_RUN;
        mem_stall = 1'b1;
      end
    endcase
  end

  // Priority: reset, memory stall, branch flush, load-use bubble.
  always_comb begin
    pc_we     = 1'b1;
    if_id_we  = 1'b1;
    id_ex_we  = 1'b1;
    ex_mem_we = 1'b1;
    mem_wb_we = 1'b1;
    if_id_fl  = 1'b0;
    id_ex_fl  = 1'b0;
    if (!rst_n || mem_stall) begin
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      id_ex_we  = 1'b0;
      ex_mem_we = 1'b0;
      mem_wb_we = 1'b0;
    end else if (hz.branch_taken_ex) begin
      if_id_fl = 1'b1;
      id_ex_fl = 1'b1;
    end else if (load_use) begin
      pc_we    = 1'b0;
      if_id_we = 1'b0;
      id_ex_fl = 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!pc_we),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (if_id_fl),
    .count (flush_cnt)
  );

  assign hz.pc_write     = pc_we;
  assign hz.if_id_write  = if_id_we;
  assign hz.id_ex_write  = id_ex_we;
  assign hz.ex_mem_write = ex_mem_we;
  assign hz.mem_wb_write = mem_wb_we;
  assign hz.if_id_flush  = if_id_fl;
  assign hz.id_ex_flush  = id_ex_fl;
  assign hz.bus_error    = bus_error_q;
  assign hz.stall_count  = stall_cnt;
  assign hz.flush_count  = flush_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed-vector bench for hazard_controller with hand-computed expectations.
module tb_hazard_controller;
  import hazard_pkg::*;

  localparam logic [6:0] C_NORM  = 7'b11111_00;
  localparam logic [6:0] C_STALL = 7'b00000_00;
  localparam logic [6:0] C_FLUSH = 7'b11111_11;
  localparam logic [6:0] C_LU    = 7'b00111_01;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  hazard_controller_if #(.CNT_W(16)) hz_if ();

  hazard_controller #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] ctl;
  assign ctl = {hz_if.pc_write, hz_if.if_id_write, hz_if.id_ex_write,
                hz_if.ex_mem_write, hz_if.mem_wb_write,
                hz_if.if_id_flush, hz_if.id_ex_flush};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic ld, input logic br, input logic req, input logic rdy);
    hz_if.ars1_if_id      = rs1;
    hz_if.ars2_if_id      = rs2;
    hz_if.ard_id_ex       = rd;
    hz_if.memread_id_ex   = ld;
    hz_if.branch_taken_ex = br;
    hz_if.dmem_req_ex_mem = req;
    hz_if.dmem_ready      = rdy;
    #1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input int stalls, input int flushes);
    chk({tag, "_stall_cnt"}, 32'(hz_if.stall_count), 32'(stalls));
    chk({tag, "_flush_cnt"}, 32'(hz_if.flush_count), 32'(flushes));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_ctl", 32'(ctl), 32'(C_STALL));
    chk("reset_bus_err", 32'(hz_if.bus_error), 32'd0);
    chk_cnt("reset", 0, 0);
    cyc();
    cyc();
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("idle", 32'(ctl), 32'(C_NORM));
    cyc();

    // Load x5 used as rs2: one bubble, then the bubble sits in EX.
    drive(5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("lu_rs2", 32'(ctl), 32'(C_LU));
    cyc();
    drive(5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("lu_after", 32'(ctl), 32'(C_NORM));
    chk_cnt("lu_rs2", 1, 0);
    cyc();

    drive(5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("lu_rs1", 32'(ctl), 32'(C_LU));
    cyc();
    chk_cnt("lu_rs1", 2, 0);

    drive(5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("alu_match", 32'(ctl), 32'(C_NORM));
    cyc();

    drive(5'd0, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("load_x0", 32'(ctl), 32'(C_NORM));
    cyc();
    chk_cnt("load_x0", 2, 0);

    drive(5'd9, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("lu_and_branch", 32'(ctl), 32'(C_FLUSH));
    cyc();
    chk_cnt("lu_and_branch", 2, 1);

    // Branch held in EX across a three-cycle memory stall.
    for (int i = 0; i < 3; i++) begin
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk($sformatf("memstall_br%0d", i), 32'(ctl), 32'(C_STALL));
      cyc();
    end
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("br_release", 32'(ctl), 32'(C_FLUSH));
    cyc();
    chk_cnt("br_release", 5, 2);

    drive(5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("memstall_over_lu", 32'(ctl), 32'(C_STALL));
    cyc();
    drive(5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("lu_release", 32'(ctl), 32'(C_LU));
    cyc();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("run_ready", 32'(ctl), 32'(C_NORM));
    cyc();
    chk_cnt("lu_release", 7, 2);

    // One RUN stall cycle plus 16 MEM_WAIT cycles reach ERROR.
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 17; i++) begin
      cyc();
      if (i == 16) chk("timeout_edge", 32'(hz_if.bus_error), 32'd0);
      if (i == 17) chk("timeout_set", 32'(hz_if.bus_error), 32'd1);
    end
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("error_stall", 32'(ctl), 32'(C_STALL));
    cyc();
    chk("error_sticky", 32'(hz_if.bus_error), 32'd1);
    chk_cnt("error", 25, 2);

    rst_n = 1'b0;
    #1;
    chk("rst_err_ctl", 32'(ctl), 32'(C_STALL));
    chk("rst_err_bus", 32'(hz_if.bus_error), 32'd0);
    chk_cnt("rst_err", 0, 0);
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_run", 32'(ctl), 32'(C_NORM));
    cyc();
    chk_cnt("post_rst", 0, 0);

    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (65540) @(posedge clk);
    #1;
    chk("sat_stall", 32'(hz_if.stall_count), 32'h0000_FFFF);
    cyc();
    chk("sat_hold", 32'(hz_if.stall_count), 32'h0000_FFFF);
    chk("sat_bus_err", 32'(hz_if.bus_error), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
